// File: rtl/tm_player_pkg.sv
// Shared types and default timing for the TuringMachine program player.
package tm_player_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LD_SETUP,
    LD_PULSE,
    LD_GAP,
    DN_PULSE,
    DN_GAP,
    RUN_SETTLE,
    RUN_PULSE,
    FINISHED
  } player_state_t;

  localparam int DEF_DATA_W     = 4;
  localparam int DEF_MAX_LEN    = 64;
  localparam int DEF_DISP_W     = 11;
  localparam int DEF_SETUP_CYC  = 3;
  localparam int DEF_PULSE_CYC  = 2;
  localparam int DEF_GAP_CYC    = 2;
  localparam int DEF_SETTLE_CYC = 5;
  localparam int DEF_STEP_LIMIT = 255;

  localparam int ADDR_W = $clog2(DEF_MAX_LEN);

  // Phase durations of 1..256 cycles fit the shared timer.
  localparam int TMR_W = 8;

  function automatic logic [TMR_W-1:0] phase_load(input int cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/tm_program_player_if.sv
// Button/display pins between the program player and the TuringMachine.
interface tm_program_player_if
  import tm_player_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DISP_W = DEF_DISP_W
) ();

  logic [DATA_W-1:0] input_data;
  logic              Next;
  logic              Done;
  logic [DISP_W-1:0] tm_display;
  logic              tm_compute_done;

  modport player  (output input_data, Next, Done, input  tm_display, tm_compute_done);
  modport machine (input  input_data, Next, Done, output tm_display, tm_compute_done);

endinterface

// File: rtl/tm_phase_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module tm_phase_timer
  import tm_player_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/tm_program_player.sv
// Plays a stored program into the TuringMachine buttons, then single-steps
// the run phase, snapshotting the display after every step.
//
// state      | meaning
// IDLE       | host may write program memory; waits for start
// LD_SETUP   | symbol held stable on input_data
// LD_PULSE   | Next high for the current symbol
// LD_GAP     | Next low before the next symbol or Done
// DN_PULSE   | Done high, ends program entry
// DN_GAP     | Done low before run phase
// RUN_SETTLE | machine settles; display sampled on the last cycle
// RUN_PULSE  | Next high, one machine step
// FINISHED   | status held; start rising edge replays the program
module tm_program_player
  import tm_player_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int DISP_W     = DEF_DISP_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int STEP_LIMIT = DEF_STEP_LIMIT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       prog_we,
  input  logic [$clog2(MAX_LEN)-1:0] prog_addr,
  input  logic [DATA_W-1:0]          prog_wdata,
  input  logic [$clog2(MAX_LEN):0]   prog_len,
  input  logic                       start,
  tm_program_player_if.player        tm,
  output logic                       busy,
  output logic                       snap_valid,
  output logic [DISP_W-1:0]          snap_display,
  output logic [7:0]                 step_count,
  output logic                       halted,
  output logic                       timeout
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam logic [7:0] LIMIT = 8'(STEP_LIMIT);

  player_state_t state, state_next;

  logic [DATA_W-1:0] mem [MAX_LEN];
  logic [LW-1:0]     len, idx, idx_inc;
  logic [DATA_W-1:0] symbol;
  logic              next_btn, done_btn;
  logic              start_q, advance, launch, sample;
  logic              expire, tmr_load;
  logic [TMR_W-1:0]  tmr_val;

  assign idx_inc = idx + LW'(1);
  assign advance = (idx_inc < len);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE:       if (start) launch = 1'b1;
      LD_SETUP:   if (expire) state_next = LD_PULSE;
      LD_PULSE:   if (expire) state_next = LD_GAP;
      LD_GAP:     if (expire) state_next = advance ? LD_SETUP : DN_PULSE;
      DN_PULSE:   if (expire) state_next = DN_GAP;
      DN_GAP:     if (expire) state_next = RUN_SETTLE;
      RUN_SETTLE: begin
        if (expire) begin
          sample = 1'b1;
          if (tm.tm_compute_done || (step_count == LIMIT)) state_next = FINISHED;
          else                                             state_next = RUN_PULSE;
        end
      end
      RUN_PULSE:  if (expire) state_next = RUN_SETTLE;
      FINISHED:   if (start && !start_q) launch = 1'b1;
      default:    state_next = IDLE;
    endcase
    // An empty program skips straight to the Done button on both launch paths.
    if (launch) state_next = (prog_len == '0) ? DN_PULSE : LD_SETUP;
  end

  always_comb begin
    tmr_load = (state_next != state);
    case (state_next)
      LD_SETUP:             tmr_val = phase_load(SETUP_CYC);
      LD_PULSE, DN_PULSE,
      RUN_PULSE:            tmr_val = phase_load(PULSE_CYC);
      LD_GAP, DN_GAP:       tmr_val = phase_load(GAP_CYC);
      RUN_SETTLE:           tmr_val = phase_load(SETTLE_CYC);
      default:              tmr_val = '0;
    endcase
  end

  tm_phase_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      len          <= '0;
      idx          <= '0;
      symbol       <= '0;
      next_btn     <= 1'b0;
      done_btn     <= 1'b0;
      snap_valid   <= 1'b0;
      snap_display <= '0;
      step_count   <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state      <= state_next;
      start_q    <= start;
      next_btn   <= (state_next == LD_PULSE) || (state_next == RUN_PULSE);
      done_btn   <= (state_next == DN_PULSE);
      snap_valid <= sample;
      if (launch) begin
        len        <= prog_len;
        idx        <= '0;
        step_count <= '0;
        halted     <= 1'b0;
        timeout    <= 1'b0;
        if (prog_len != '0) symbol <= mem[0];
      end
      if ((state == LD_GAP) && expire && advance) begin
        idx    <= idx_inc;
        symbol <= mem[idx_inc[AW-1:0]];
      end
      if (sample) begin
        snap_display <= tm.tm_display;
        if (tm.tm_compute_done)       halted  <= 1'b1;
        else if (step_count == LIMIT) timeout <= 1'b1;
      end
      if ((state == RUN_PULSE) && expire && (step_count != 8'hFF))
        step_count <= step_count + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (prog_we && (state == IDLE)) mem[prog_addr] <= prog_wdata;
  end

  assign busy          = (state != IDLE) && (state != FINISHED);
  assign tm.input_data = symbol;
  assign tm.Next       = next_btn;
  assign tm.Done       = done_btn;

endmodule

// File: tb/tb_tm_program_player.sv
// Bench for tm_program_player: two instances (default limit and limit 4)
// driven against behavioural TuringMachine models and a button-trace model.
module tb_tm_program_player;

  localparam int SETUP  = 3;
  localparam int PULSE  = 2;
  localparam int GAP    = 2;
  localparam int SETTLE = 5;
  localparam int LIM1   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       prog_we = 1'b0;
  logic [5:0] prog_addr = '0;
  logic [3:0] prog_wdata = '0;
  logic [6:0] prog_len = '0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       model_clr = 1'b0;
  logic [10:0] disp_base = '0;
  int         halt_after0 = 0;

  always #5 clock = ~clock;

  tm_program_player_if #(.DATA_W(4), .DISP_W(11)) m0 ();
  tm_program_player_if #(.DATA_W(4), .DISP_W(11)) m1 ();

  logic        busy0, sv0, halted0, timeout0, busy1, sv1, halted1, timeout1;
  logic [10:0] snap0, snap1;
  logic [7:0]  step0, step1;

  tm_program_player dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start0), .tm(m0),
    .busy(busy0), .snap_valid(sv0), .snap_display(snap0), .step_count(step0),
    .halted(halted0), .timeout(timeout0)
  );

  tm_program_player #(.STEP_LIMIT(LIM1)) dut_lim (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start1), .tm(m1),
    .busy(busy1), .snap_valid(sv1), .snap_display(snap1), .step_count(step1),
    .halted(halted1), .timeout(timeout1)
  );

  // Machine models: count Next pulses after Done; display reflects the count.
  int   pulses0 = 0, pulses1 = 0;
  logic run0, run1, nprev0, nprev1;

  always @(posedge clock) begin
    if (reset || model_clr) begin
      run0 <= 1'b0; pulses0 <= 0; nprev0 <= 1'b0;
    end else begin
      if (m0.Done) run0 <= 1'b1;
      nprev0 <= m0.Next;
      if (run0 && m0.Next && !nprev0) pulses0 <= pulses0 + 1;
    end
  end

  always @(posedge clock) begin
    if (reset || model_clr) begin
      run1 <= 1'b0; pulses1 <= 0; nprev1 <= 1'b0;
    end else begin
      if (m1.Done) run1 <= 1'b1;
      nprev1 <= m1.Next;
      if (run1 && m1.Next && !nprev1) pulses1 <= pulses1 + 1;
    end
  end

  assign m0.tm_display      = disp_base ^ 11'(pulses0 * 37);
  assign m0.tm_compute_done = (pulses0 >= halt_after0);
  assign m1.tm_display      = disp_base ^ 11'(pulses1 * 37);
  assign m1.tm_compute_done = 1'b0;

  bit          sel = 1'b0;
  logic [3:0]  o_data;
  logic        o_next, o_done, o_busy, o_sv, o_halted, o_timeout;
  logic [10:0] o_snap;
  logic [7:0]  o_step;

  always_comb begin
    if (sel) begin
      o_data = m1.input_data; o_next = m1.Next; o_done = m1.Done; o_busy = busy1;
      o_sv = sv1; o_snap = snap1; o_step = step1; o_halted = halted1; o_timeout = timeout1;
    end else begin
      o_data = m0.input_data; o_next = m0.Next; o_done = m0.Done; o_busy = busy0;
      o_sv = sv0; o_snap = snap0; o_step = step0; o_halted = halted0; o_timeout = timeout0;
    end
  end

  int         n_cmp = 0, n_bad = 0;
  logic [3:0] shadow [64];
  logic [3:0] exp_last = '0;

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; start0 = 1'b0; start1 = 1'b0; prog_we = 1'b0;
    @(negedge clock); reset = 1'b0; exp_last = '0;
  endtask

  task automatic load_mem(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clock); prog_we = 1'b1; prog_addr = 6'(i); prog_wdata = shadow[i];
    end
    @(negedge clock); prog_we = 1'b0;
  endtask

  // Expected button trace built from the protocol rules, then the run phase.
  task automatic run_program(input int len, input bit poke, input bit hold);
    logic [3:0] q_data[$];
    logic       q_next[$], q_done[$];
    logic [3:0] cur;
    int lim, exp_steps, cyc, snaps, prev_snap, budget, exp_at;
    bit exp_halted, both;
    cur = exp_last;
    for (int s = 0; s < len; s++) begin
      cur = shadow[s];
      for (int k = 0; k < SETUP; k++) begin q_data.push_back(cur); q_next.push_back(1'b0); q_done.push_back(1'b0); end
      for (int k = 0; k < PULSE; k++) begin q_data.push_back(cur); q_next.push_back(1'b1); q_done.push_back(1'b0); end
      for (int k = 0; k < GAP; k++)   begin q_data.push_back(cur); q_next.push_back(1'b0); q_done.push_back(1'b0); end
    end
    for (int k = 0; k < PULSE; k++) begin q_data.push_back(cur); q_next.push_back(1'b0); q_done.push_back(1'b1); end
    for (int k = 0; k < GAP; k++)   begin q_data.push_back(cur); q_next.push_back(1'b0); q_done.push_back(1'b0); end
    lim        = sel ? LIM1 : 255;
    exp_halted = !sel && (halt_after0 <= lim);
    exp_steps  = exp_halted ? halt_after0 : lim;
    disp_base  = 11'($urandom);

    @(negedge clock);
    prog_len = 7'(len); model_clr = 1'b1;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    for (int c = 0; c < q_data.size(); c++) begin
      @(negedge clock);
      model_clr = 1'b0;
      if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
      n_cmp++;
      if ({o_data, o_next, o_done, o_busy, o_halted, o_timeout, o_step} !==
          {q_data[c], q_next[c], q_done[c], 1'b1, 1'b0, 1'b0, 8'd0}) begin
        n_bad++;
        $display("FAIL trace cycle %0d: got data=%0d next=%0b done=%0b busy=%0b halted=%0b timeout=%0b step=%0d, required data=%0d next=%0b done=%0b busy=1 halted=0 timeout=0 step=0",
                 c + 1, o_data, o_next, o_done, o_busy, o_halted, o_timeout, o_step, q_data[c], q_next[c], q_done[c]);
      end
    end

    cyc = q_data.size(); snaps = 0; prev_snap = 0; both = 1'b0; budget = 3000;
    forever begin
      @(negedge clock);
      cyc++; budget--;
      if (poke) begin
        if (cyc == q_data.size() + 2) begin prog_we = 1'b1; prog_addr = '0; prog_wdata = ~shadow[0]; end
        else prog_we = 1'b0;
      end
      if (o_next && o_done) both = 1'b1;
      if (o_sv) begin
        n_cmp++;
        if (o_snap !== (disp_base ^ 11'(snaps * 37))) begin
          n_bad++; $display("FAIL snap_display step %0d: got %0h, required %0h", snaps, o_snap, disp_base ^ 11'(snaps * 37));
        end
        n_cmp++;
        if (o_step !== 8'(snaps)) begin
          n_bad++; $display("FAIL snap step_count: got %0d, required %0d", o_step, snaps);
        end
        exp_at = (snaps == 0) ? q_data.size() + SETTLE + 1 : prev_snap + PULSE + SETTLE;
        n_cmp++;
        if (cyc != exp_at) begin
          n_bad++; $display("FAIL snap timing %0d: got cycle %0d, required cycle %0d", snaps, cyc, exp_at);
        end
        prev_snap = cyc; snaps++;
      end
      if (!o_busy) break;
      if (budget == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL run budget: busy still %0b after 3000 cycles, required 0", o_busy);
        break;
      end
    end
    prog_we = 1'b0;

    n_cmp++;
    if (snaps != exp_steps + 1) begin
      n_bad++; $display("FAIL snap count: got %0d, required %0d", snaps, exp_steps + 1);
    end
    n_cmp++;
    if ({o_halted, o_timeout} !== {exp_halted, !exp_halted}) begin
      n_bad++; $display("FAIL status: got halted=%0b timeout=%0b, required halted=%0b timeout=%0b", o_halted, o_timeout, exp_halted, !exp_halted);
    end
    n_cmp++;
    if (o_step !== 8'(exp_steps)) begin
      n_bad++; $display("FAIL final step_count: got %0d, required %0d", o_step, exp_steps);
    end
    n_cmp++;
    if ({o_busy, o_next, o_done, both} !== 4'b0000) begin
      n_bad++; $display("FAIL idle buttons: got busy=%0b next=%0b done=%0b overlap=%0b, required all 0", o_busy, o_next, o_done, both);
    end
    if (len > 0) exp_last = shadow[len-1];
  endtask

  task automatic test_reset();
    @(negedge clock); @(negedge clock);
    n_cmp++;
    if (m0.Next !== 1'b0) begin n_bad++; $display("FAIL reset Next: got %0b, required 0", m0.Next); end
    n_cmp++;
    if (m0.Done !== 1'b0) begin n_bad++; $display("FAIL reset Done: got %0b, required 0", m0.Done); end
    n_cmp++;
    if ({m0.input_data, busy0, sv0, snap0, step0, halted0, timeout0} !== '0) begin
      n_bad++; $display("FAIL reset outputs: got data=%0d busy=%0b sv=%0b snap=%0h step=%0d halted=%0b timeout=%0b, required all 0",
                        m0.input_data, busy0, sv0, snap0, step0, halted0, timeout0);
    end
    n_cmp++;
    if ({m1.input_data, m1.Next, m1.Done, busy1, sv1, snap1, step1, halted1, timeout1} !== '0) begin
      n_bad++; $display("FAIL reset outputs lim: got data=%0d busy=%0b step=%0d, required all 0", m1.input_data, busy1, step1);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_three_symbols();
    shadow[0] = 4'd3; shadow[1] = 4'd1; shadow[2] = 4'd0;
    load_mem(3);
    halt_after0 = 10;
    run_program(3, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    do_reset();
    halt_after0 = $urandom_range(1, 5);
    run_program(0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) shadow[i] = 4'($urandom);
      load_mem(len);
      halt_after0 = (r == 0) ? 0 : $urandom_range(1, 6);
      run_program(len, 1'b0, 1'b0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    sel = 1'b1;
    shadow[0] = 4'($urandom); shadow[1] = 4'($urandom);
    load_mem(2);
    run_program(2, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    for (int i = 0; i < 3; i++) shadow[i] = 4'($urandom_range(1, 15));
    load_mem(3);
    halt_after0 = 3;
    @(negedge clock); prog_len = 7'd3; start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    w = 0;
    while (!o_next && w < 20) begin @(negedge clock); w++; end
    n_cmp++;
    if (o_next !== 1'b1) begin n_bad++; $display("FAIL reset_mid wait: Next got %0b, required 1", o_next); end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (o_next !== 1'b0) begin n_bad++; $display("FAIL reset_mid Next: got %0b, required 0", o_next); end
    n_cmp++;
    if ({o_data, o_done, o_busy, o_sv, o_snap, o_step, o_halted, o_timeout} !== '0) begin
      n_bad++; $display("FAIL reset_mid outputs: got data=%0d done=%0b busy=%0b step=%0d, required all 0", o_data, o_done, o_busy, o_step);
    end
    @(negedge clock); reset = 1'b0; exp_last = '0;
    run_program(3, 1'b0, 1'b0);
  endtask

  task automatic test_write_during_run();
    do_reset();
    for (int i = 0; i < 3; i++) shadow[i] = 4'($urandom);
    load_mem(3);
    halt_after0 = 2;
    run_program(3, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({o_busy, o_halted, o_step} !== {1'b0, 1'b1, 8'd2}) begin
      n_bad++; $display("FAIL finished hold: got busy=%0b halted=%0b step=%0d, required busy=0 halted=1 step=2", o_busy, o_halted, o_step);
    end
    start0 = 1'b0;
    run_program(3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_three_symbols();
    test_zero_len();
    test_random();
    test_timeout();
    test_reset_mid();
    test_write_during_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2ms, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
